mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state changes on the rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have ports Instr_MEM, ALUout_MEM (effective address), RT_MEM (store data), PC8_MEM and CP0_RD_MEM: inputs, 32 bits each.
REQ-004 SHALL have ports Instr_WB, ALUout_WB, DM_RD_WB, PC8_WB and CP0_RD_WB: outputs, 32 bits each, all registered, feeding the write-back stage.
REQ-005 SHALL have port Stall_MEM, output, 1 bit: holds all upstream stages.
REQ-006 SHALL have bus outputs bus_req (1), bus_we (1), bus_be (4), bus_addr (32) and bus_wdata (32).
REQ-007 SHALL have bus inputs bus_rdata (32) and bus_ack (1).
REQ-008 SHALL have ports Exc_AdEL, Exc_AdES and BusErr: outputs, 1 bit each, combinational pulses.

Function
REQ-009 SHALL decode memory ops from Instr_MEM[31:26]:
- loads: lw 0x23, lh 0x21, lhu 0x25, lb 0x20, lbu 0x24.
- stores: sw 0x2B, sh 0x29, sb 0x28.
- every other opcode is a non-memory op.
REQ-010 SHALL register every non-memory op into the WB outputs in 1 cycle, with DM_RD_WB=0 and Stall_MEM=0.
REQ-011 SHALL implement FSM states IDLE and WAIT, transitioning as follows:
- IDLE to WAIT on an aligned memory op.
- WAIT to IDLE on the cycle bus_ack=1 is sampled.
REQ-012 SHALL drive bus_req=1 only in WAIT, with bus_addr={ALUout_MEM[31:2],2'b00} and bus_we=1 for stores.
REQ-013 SHALL assert Stall_MEM combinationally for an aligned memory op except in WAIT with bus_ack=1; minimum memory-op latency is 2 cycles.
REQ-014 SHALL load a bubble into the WB outputs (all zero, Instr_WB=0x00000000) on every edge while Stall_MEM=1.
REQ-015 SHALL capture the WB outputs at the edge where bus_ack=1 is sampled in WAIT.
REQ-016 SHALL set bus_be for stores as follows:
- sw: 4'b1111.
- sh: 4'b0011 when addr[1]=0, else 4'b1100.
- sb: 4'b0001<<addr[1:0].
REQ-017 SHALL form bus_wdata by replicating RT_MEM[7:0] for sb and RT_MEM[15:0] for sh, and use RT_MEM for sw.
REQ-018 SHALL extract load data little-endian using addr[1:0]: lb/lh sign-extend, lbu/lhu zero-extend, lw takes the word unchanged; the result goes to DM_RD_WB.
REQ-019 SHALL treat misalignment as lw/sw with addr[1:0]!=0, or lh/lhu/sh with addr[0]=1.
REQ-020 SHALL respond to a misaligned op in IDLE by pulsing Exc_AdEL (loads) or Exc_AdES (stores) for 1 cycle, starting no bus cycle, keeping Stall_MEM=0, and passing a bubble to WB.
REQ-021 SHALL ignore bus_ack outside WAIT.
REQ-022 SHALL start no new request in the cycle bus_ack=1 is sampled; back-to-back memory ops re-enter WAIT from IDLE.

Reset
REQ-023 SHALL, on reset assertion and even mid-transaction, force IDLE immediately.
REQ-024 SHALL hold bus_req, Stall_MEM, Exc_AdEL, Exc_AdES and BusErr at 0 and all WB outputs at 0 while reset is asserted.
REQ-025 SHALL drop any in-flight transaction on reset; a late bus_ack after reset release is ignored.

Configuration
REQ-026 SHALL, with MEM_BUS_TIMEOUT_EN defined, keep an 8-bit counter that clears on entry to WAIT and increments each WAIT cycle without ack.
REQ-027 SHALL, with MEM_BUS_TIMEOUT_EN defined, respond to the counter reaching 255 by:
- pulsing BusErr for 1 cycle;
- dropping Stall_MEM;
- retiring a bubble to WB;
- returning to IDLE.
REQ-028 SHALL, without MEM_BUS_TIMEOUT_EN, wait in WAIT indefinitely, tie BusErr to 0, and omit the counter.

Verification
REQ-029 SHALL verify that addu followed by ori produce Instr_WB one cycle after each is presented, with Stall_MEM never asserted.
REQ-030 SHALL verify that lb at addr 0x1003 with bus_rdata 0x80FF_FF12 and ack after 3 wait cycles gives DM_RD_WB=0xFFFFFF80, Stall_MEM high for 4 cycles, and 4 bubbles to WB.
REQ-031 SHALL verify that sh at 0x2002 with RT_MEM 0x1234ABCD gives bus_be=4'b1100, bus_wdata=0xABCDABCD and bus_we=1.
REQ-032 SHALL verify that lw at 0x3001 gives an Exc_AdEL 1-cycle pulse, bus_req staying 0, and a bubble to WB.
REQ-033 SHALL verify that reset asserted in WAIT before ack gives bus_req=0 immediately, an ack 2 cycles later ignored, and all WB outputs 0.
REQ-034 SHALL verify that, with MEM_BUS_TIMEOUT_EN and ack never asserted, BusErr pulses once 255 WAIT cycles after entry and the stage then accepts the next instruction.

Source files
------------

// File: rtl/mem_stage.sv
// MEM pipeline stage: decodes loads/stores, runs a req/ack bus handshake and registers WB outputs.
// Optional bus watchdog enabled by defining MEM_BUS_TIMEOUT_EN.
module mem_stage (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] Instr_MEM,
   input  logic [31:0] ALUout_MEM,
   input  logic [31:0] RT_MEM,
   input  logic [31:0] PC8_MEM,
   input  logic [31:0] CP0_RD_MEM,
   output logic [31:0] Instr_WB,
   output logic [31:0] ALUout_WB,
   output logic [31:0] DM_RD_WB,
   output logic [31:0] PC8_WB,
   output logic [31:0] CP0_RD_WB,
   output logic        Stall_MEM,
   output logic        bus_req,
   output logic        bus_we,
   output logic [3:0]  bus_be,
   output logic [31:0] bus_addr,
   output logic [31:0] bus_wdata,
   input  logic [31:0] bus_rdata,
   input  logic        bus_ack,
   output logic        Exc_AdEL,
   output logic        Exc_AdES,
   output logic        BusErr
);

   typedef enum logic [0:0] {StIdle, StWait} state_e;

   state_e      state_q, state_d;
   logic [5:0]  opcode;
   logic [1:0]  addr_lo;
   logic        is_lw, is_lh, is_lhu, is_lb, is_lbu, is_sw, is_sh, is_sb;
   logic        is_load, is_store, misaligned, aligned_op, in_wait, timeout, wb_bubble;
   logic [7:0]  lane_byte;
   logic [15:0] lane_half;
   logic [31:0] load_data;

   assign opcode  = Instr_MEM[31:26];
   assign addr_lo = ALUout_MEM[1:0];

   always_comb begin
      is_lw  = 1'b0;
      is_lh  = 1'b0;
      is_lhu = 1'b0;
      is_lb  = 1'b0;
      is_lbu = 1'b0;
      is_sw  = 1'b0;
      is_sh  = 1'b0;
      is_sb  = 1'b0;
      case (opcode)
         6'h23:   is_lw  = 1'b1;
         6'h21:   is_lh  = 1'b1;
         6'h25:   is_lhu = 1'b1;
         6'h20:   is_lb  = 1'b1;
         6'h24:   is_lbu = 1'b1;
         6'h2B:   is_sw  = 1'b1;
         6'h29:   is_sh  = 1'b1;
         6'h28:   is_sb  = 1'b1;
         default: ;
      endcase
   end

   assign is_load    = is_lw | is_lh | is_lhu | is_lb | is_lbu;
   assign is_store   = is_sw | is_sh | is_sb;
   assign misaligned = ((is_lw | is_sw) & (addr_lo != 2'b00)) |
                       ((is_lh | is_lhu | is_sh) & addr_lo[0]);
   assign aligned_op = (is_load | is_store) & ~misaligned;
   assign in_wait    = (state_q == StWait);

`ifdef MEM_BUS_TIMEOUT_EN
   logic [7:0] cnt_q, cnt_d;

   // Counter holds the number of ack-less WAIT cycles seen so far.
   always_comb begin
      cnt_d = cnt_q;
      if (!in_wait)      cnt_d = 8'd0;
      else if (!bus_ack) cnt_d = cnt_q + 8'd1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) cnt_q <= 8'd0;
      else       cnt_q <= cnt_d;
   end

   assign timeout = in_wait & ~bus_ack & (cnt_q == 8'hFF);
`else
   assign timeout = 1'b0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= StIdle;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: if (aligned_op) state_d = StWait;
         StWait: if (bus_ack || timeout) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      bus_req   = ~reset & in_wait;
      bus_we    = bus_req & is_store;
      bus_addr  = {ALUout_MEM[31:2], 2'b00};
      Stall_MEM = ~reset & aligned_op & ~(in_wait & bus_ack) & ~timeout;
      Exc_AdEL  = ~reset & ~in_wait & is_load & misaligned;
      Exc_AdES  = ~reset & ~in_wait & is_store & misaligned;
      BusErr    = ~reset & timeout;
   end

   always_comb begin
      bus_be = 4'b0000;
      if (is_sw)      bus_be = 4'b1111;
      else if (is_sh) bus_be = addr_lo[1] ? 4'b1100 : 4'b0011;
      else if (is_sb) bus_be = 4'b0001 << addr_lo;
   end

   always_comb begin
      bus_wdata = RT_MEM;
      if (is_sb)      bus_wdata = {4{RT_MEM[7:0]}};
      else if (is_sh) bus_wdata = {2{RT_MEM[15:0]}};
   end

   // Little-endian lane select from the returned word.
   assign lane_byte = bus_rdata[{addr_lo, 3'b000} +: 8];
   assign lane_half = addr_lo[1] ? bus_rdata[31:16] : bus_rdata[15:0];

   always_comb begin
      load_data = 32'd0;
      if (is_lb)       load_data = {{24{lane_byte[7]}}, lane_byte};
      else if (is_lbu) load_data = {24'd0, lane_byte};
      else if (is_lh)  load_data = {{16{lane_half[15]}}, lane_half};
      else if (is_lhu) load_data = {16'd0, lane_half};
      else if (is_lw)  load_data = bus_rdata;
   end

   assign wb_bubble = Stall_MEM | Exc_AdEL | Exc_AdES | timeout;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         Instr_WB  <= 32'd0;
         ALUout_WB <= 32'd0;
         DM_RD_WB  <= 32'd0;
         PC8_WB    <= 32'd0;
         CP0_RD_WB <= 32'd0;
      end else if (wb_bubble) begin
         Instr_WB  <= 32'd0;
         ALUout_WB <= 32'd0;
         DM_RD_WB  <= 32'd0;
         PC8_WB    <= 32'd0;
         CP0_RD_WB <= 32'd0;
      end else begin
         Instr_WB  <= Instr_MEM;
         ALUout_WB <= ALUout_MEM;
         DM_RD_WB  <= is_load ? load_data : 32'd0;
         PC8_WB    <= PC8_MEM;
         CP0_RD_WB <= CP0_RD_MEM;
      end
   end

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage; the watchdog section runs when MEM_BUS_TIMEOUT_EN is defined.
module tb_mem_stage;

   logic        clk, reset;
   logic [31:0] Instr_MEM, ALUout_MEM, RT_MEM, PC8_MEM, CP0_RD_MEM;
   logic [31:0] Instr_WB, ALUout_WB, DM_RD_WB, PC8_WB, CP0_RD_WB;
   logic        Stall_MEM, bus_req, bus_we, bus_ack;
   logic [3:0]  bus_be;
   logic [31:0] bus_addr, bus_wdata, bus_rdata;
   logic        Exc_AdEL, Exc_AdES, BusErr;

   int checks   = 0;
   int failures = 0;
   int stalls, bubbles, n;

   localparam logic [31:0] ADDU = 32'h0085_1021;
   localparam logic [31:0] ORI  = 32'h34A5_00FF;
   localparam logic [31:0] LB   = 32'h80A4_0000;
   localparam logic [31:0] LHU  = 32'h94A4_0000;
   localparam logic [31:0] LW   = 32'h8CA4_0000;
   localparam logic [31:0] SW   = 32'hACA5_0000;
   localparam logic [31:0] SH   = 32'hA4A5_0000;
   localparam logic [31:0] SB   = 32'hA0A5_0000;

   mem_stage dut (
      .clk        (clk),
      .reset      (reset),
      .Instr_MEM  (Instr_MEM),
      .ALUout_MEM (ALUout_MEM),
      .RT_MEM     (RT_MEM),
      .PC8_MEM    (PC8_MEM),
      .CP0_RD_MEM (CP0_RD_MEM),
      .Instr_WB   (Instr_WB),
      .ALUout_WB  (ALUout_WB),
      .DM_RD_WB   (DM_RD_WB),
      .PC8_WB     (PC8_WB),
      .CP0_RD_WB  (CP0_RD_WB),
      .Stall_MEM  (Stall_MEM),
      .bus_req    (bus_req),
      .bus_we     (bus_we),
      .bus_be     (bus_be),
      .bus_addr   (bus_addr),
      .bus_wdata  (bus_wdata),
      .bus_rdata  (bus_rdata),
      .bus_ack    (bus_ack),
      .Exc_AdEL   (Exc_AdEL),
      .Exc_AdES   (Exc_AdES),
      .BusErr     (BusErr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [31:0] instr, input logic [31:0] alu);
      Instr_MEM  = instr;
      ALUout_MEM = alu;
      #1;
   endtask

   initial begin
      reset = 1'b1; bus_ack = 1'b0; bus_rdata = 32'd0; RT_MEM = 32'd0;
      PC8_MEM = 32'h0000_0104; CP0_RD_MEM = 32'h0000_0077;
      drive(LW, 32'h0000_0000);
      tick();
      // Reset holds everything low even with a memory op presented.
      chk1("rst_stall", Stall_MEM, 1'b0);
      chk1("rst_req", bus_req, 1'b0);
      chk1("rst_buserr", BusErr, 1'b0);
      chk("rst_instr_wb", Instr_WB, 32'd0);
      chk("rst_pc8_wb", PC8_WB, 32'd0);
      drive(32'd0, 32'd0);
      reset = 1'b0;
      tick();

      // addu then ori: one-cycle pass-through, no stall.
      drive(ADDU, 32'h0000_0055);
      chk1("addu_stall", Stall_MEM, 1'b0);
      tick();
      chk("addu_instr_wb", Instr_WB, ADDU);
      chk("addu_alu_wb", ALUout_WB, 32'h0000_0055);
      chk("addu_dm_wb", DM_RD_WB, 32'd0);
      chk("addu_pc8_wb", PC8_WB, 32'h0000_0104);
      chk("addu_cp0_wb", CP0_RD_WB, 32'h0000_0077);
      PC8_MEM = 32'h0000_0108;
      drive(ORI, 32'h0000_00AA);
      chk1("ori_stall", Stall_MEM, 1'b0);
      tick();
      chk("ori_instr_wb", Instr_WB, ORI);
      chk("ori_pc8_wb", PC8_WB, 32'h0000_0108);

      // lb at 0x1003, ack after three wait cycles.
      bus_rdata = 32'h80FF_FF12;
      drive(LB, 32'h0000_1003);
      chk1("lb_idle_req", bus_req, 1'b0);
      stalls = 0; bubbles = 0;
      for (int i = 0; i < 4; i++) begin
         if (Stall_MEM) stalls++;
         tick();
         if (Instr_WB == 32'd0) bubbles++;
      end
      chk1("lb_wait_req", bus_req, 1'b1);
      chk("lb_addr", bus_addr, 32'h0000_1000);
      chk1("lb_we", bus_we, 1'b0);
      bus_ack = 1'b1;
      #1;
      chk1("lb_ack_stall", Stall_MEM, 1'b0);
      tick();
      bus_ack = 1'b0;
      chk("lb_stall_cycles", stalls, 32'd4);
      chk("lb_bubbles", bubbles, 32'd4);
      chk("lb_instr_wb", Instr_WB, LB);
      chk("lb_dm_wb", DM_RD_WB, 32'hFFFF_FF80);
      chk("lb_alu_wb", ALUout_WB, 32'h0000_1003);
      chk1("lb_done_req", bus_req, 1'b0);

      // lhu at 0x1002 with ack in the first wait cycle (minimum latency).
      drive(LHU, 32'h0000_1002);
      chk1("lhu_stall", Stall_MEM, 1'b1);
      tick();
      chk("lhu_bubble", Instr_WB, 32'd0);
      bus_ack = 1'b1;
      #1;
      tick();
      bus_ack = 1'b0;
      chk("lhu_dm_wb", DM_RD_WB, 32'h0000_80FF);

      // sh at 0x2002: upper halfword lanes.
      RT_MEM = 32'h1234_ABCD;
      drive(SH, 32'h0000_2002);
      tick();
      chk("sh_be", {28'd0, bus_be}, 32'h0000_000C);
      chk("sh_wdata", bus_wdata, 32'hABCD_ABCD);
      chk1("sh_we", bus_we, 1'b1);
      chk("sh_addr", bus_addr, 32'h0000_2000);
      bus_ack = 1'b1;
      #1;
      tick();
      bus_ack = 1'b0;
      chk("sh_instr_wb", Instr_WB, SH);
      chk("sh_dm_wb", DM_RD_WB, 32'd0);

      // sb at 0x2001: byte lane 1, replicated data.
      RT_MEM = 32'h0000_00EF;
      drive(SB, 32'h0000_2001);
      tick();
      chk("sb_be", {28'd0, bus_be}, 32'h0000_0002);
      chk("sb_wdata", bus_wdata, 32'hEFEF_EFEF);
      bus_ack = 1'b1;
      #1;
      tick();
      bus_ack = 1'b0;
      chk("sb_instr_wb", Instr_WB, SB);

      // Misaligned lw: AdEL pulse, no bus cycle, bubble to WB.
      drive(LW, 32'h0000_3001);
      chk1("adel_pulse", Exc_AdEL, 1'b1);
      chk1("adel_ades", Exc_AdES, 1'b0);
      chk1("adel_stall", Stall_MEM, 1'b0);
      chk1("adel_req", bus_req, 1'b0);
      tick();
      chk("adel_bubble", Instr_WB, 32'd0);
      chk1("adel_req_after", bus_req, 1'b0);
      drive(ADDU, 32'h0000_0001);
      chk1("adel_cleared", Exc_AdEL, 1'b0);
      tick();

      // Misaligned sw: AdES pulse.
      drive(SW, 32'h0000_3002);
      chk1("ades_pulse", Exc_AdES, 1'b1);
      chk1("ades_adel", Exc_AdEL, 1'b0);
      tick();
      chk("ades_bubble", Instr_WB, 32'd0);

      // Reset mid-transaction; a late ack must be ignored.
      drive(LW, 32'h0000_4000);
      tick();
      chk1("rstw_req_before", bus_req, 1'b1);
      reset = 1'b1;
      #1;
      chk1("rstw_req", bus_req, 1'b0);
      chk1("rstw_stall", Stall_MEM, 1'b0);
      chk("rstw_instr_wb", Instr_WB, 32'd0);
      chk("rstw_alu_wb", ALUout_WB, 32'd0);
      drive(32'd0, 32'h0000_0009);
      tick();
      reset = 1'b0;
      tick();
      bus_ack = 1'b1;
      #1;
      chk1("late_ack_req", bus_req, 1'b0);
      chk1("late_ack_stall", Stall_MEM, 1'b0);
      tick();
      bus_ack = 1'b0;
      chk("late_ack_dm_wb", DM_RD_WB, 32'd0);
      drive(ADDU, 32'h0000_0002);
      tick();
      chk("post_rst_instr_wb", Instr_WB, ADDU);
      chk1("post_rst_req", bus_req, 1'b0);

`ifdef MEM_BUS_TIMEOUT_EN
      // Watchdog: BusErr in the 256th WAIT cycle, i.e. 255 cycles after entry.
      drive(LW, 32'h0000_5000);
      n = 0;
      while (!BusErr && n < 300) begin
         tick();
         n++;
      end
      chk("to_cycles", n, 32'd256);
      chk1("to_buserr", BusErr, 1'b1);
      chk1("to_stall", Stall_MEM, 1'b0);
      tick();
      chk("to_bubble", Instr_WB, 32'd0);
      chk1("to_req", bus_req, 1'b0);
      drive(ORI, 32'h0000_0003);
      chk1("to_buserr_once", BusErr, 1'b0);
      tick();
      chk("to_next_instr", Instr_WB, ORI);
`else
      // Without the watchdog the stage waits for ack indefinitely.
      drive(LW, 32'h0000_5000);
      stalls = 0;
      for (int i = 0; i < 300; i++) begin
         if (Stall_MEM && !BusErr) stalls++;
         tick();
      end
      chk("nto_stall_cycles", stalls, 32'd300);
      chk1("nto_req", bus_req, 1'b1);
      bus_ack = 1'b1;
      bus_rdata = 32'hDEAD_BEEF;
      #1;
      tick();
      bus_ack = 1'b0;
      chk("nto_dm_wb", DM_RD_WB, 32'hDEAD_BEEF);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
